// File: rtl/float_type_classifier_if.sv
// float_type_classifier_if: operand in, classified result out.
// master drives the operand side; slave is the classifier.
interface float_type_classifier_if;
    logic        in_valid;
    logic [31:0] num;
    logic        out_valid;
    logic [4:0]  float_type;
    logic        sign;
    logic        is_snan;
    logic        is_qnan;

    modport master (
        output in_valid, num,
        input  out_valid, float_type, sign, is_snan, is_qnan
    );

    modport slave (
        input  in_valid, num,
        output out_valid, float_type, sign, is_snan, is_qnan
    );
endinterface

// File: rtl/float_type_classifier.sv
// float_type_classifier: binary32 class decode, one register stage.
// One-hot class {nan, inf, sub, normal, zero} plus sign and NaN kind.
module float_type_classifier (
    input logic                    clk,
    input logic                    rst_n,
    float_type_classifier_if.slave bus
);
    localparam logic [4:0] ZERO = 5'b00001;
    localparam logic [4:0] NORM = 5'b00010;
    localparam logic [4:0] SUBN = 5'b00100;
    localparam logic [4:0] INF  = 5'b01000;
    localparam logic [4:0] NAN  = 5'b10000;

    logic [7:0]  e;
    logic [22:0] f;
    logic        exp_zero;
    logic        exp_ones;
    logic        frac_zero;
    logic [4:0]  type_d;
    logic        snan_d;
    logic        qnan_d;

    assign e         = bus.num[30:23];
    assign f         = bus.num[22:0];
    assign exp_zero  = (e == 8'h00);
    assign exp_ones  = (e == 8'hFF);
    assign frac_zero = (f == 23'd0);

    // Combinational class and NaN-kind decode of the incoming operand
    always_comb begin
        type_d = NORM;
        snan_d = 1'b0;
        qnan_d = 1'b0;
        unique case (1'b1)
            exp_zero && frac_zero:  type_d = ZERO;
            exp_zero && !frac_zero: type_d = SUBN;
            exp_ones && frac_zero:  type_d = INF;
            exp_ones && !frac_zero: begin
                type_d = NAN;
                qnan_d = f[22];
                snan_d = ~f[22];
            end
            default:                type_d = NORM;
        endcase
    end

    // Result register: valid follows in_valid, payload loads only on valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.float_type <= 5'b00000;
            bus.sign       <= 1'b0;
            bus.is_snan    <= 1'b0;
            bus.is_qnan    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.float_type <= type_d;
                bus.sign       <= bus.num[31];
                bus.is_snan    <= snan_d;
                bus.is_qnan    <= qnan_d;
            end
        end
    end
endmodule

// File: tb/tb_float_type_classifier.sv
// tb_float_type_classifier: directed and random checks of the classifier
// against a behavioural model of the binary32 class rules.
module tb_float_type_classifier;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    float_type_classifier_if bus ();

    float_type_classifier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model packs {float_type[4:0], sign, is_snan, is_qnan}
    logic [7:0] hold_exp;

    function automatic logic [7:0] model(input logic [31:0] n);
        int unsigned e;
        int unsigned f;
        int unsigned s;
        int          cls;
        logic [4:0]  oh;
        logic        sn;
        logic        qn;
        e   = (n / 32'h0080_0000) % 256;
        f   = n % 32'h0080_0000;
        s   = n / 32'h8000_0000;
        sn  = 1'b0;
        qn  = 1'b0;
        if (e == 0 && f == 0)        cls = 0;
        else if (e == 0)             cls = 2;
        else if (e == 255 && f == 0) cls = 3;
        else if (e == 255) begin
            cls = 4;
            if (f >= 32'h0040_0000) qn = 1'b1;
            else                    sn = 1'b1;
        end else                     cls = 1;
        oh = 5'(1 << cls);
        return {oh, s[0], sn, qn};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.float_type, bus.sign, bus.is_snan, bus.is_qnan};
    endfunction

    task automatic apply(input logic v, input logic [31:0] n);
        @(negedge clk);
        bus.in_valid = v;
        bus.num      = n;
        @(posedge clk);
        #1;
        if (v) hold_exp = model(n);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.num      = 32'h3F80_0000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || observed() !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got v=%b o=%h want v=0 o=00",
                     bus.out_valid, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 32'h3F80_0000);
        total++;
        if (bus.out_valid !== 1'b1 || bus.float_type !== 5'b00010) begin
            bad++;
            $display("FAIL reset_release got v=%b t=%b want v=1 t=00010",
                     bus.out_valid, bus.float_type);
        end
    endtask

    task automatic test_directed();
        logic [31:0] nums [15];
        logic [4:0]  types [15];
        logic [2:0]  flags [15];
        nums  = '{32'hFF80_0000, 32'h7F80_0000, 32'h0000_0000,
                  32'h8000_0000, 32'h0000_0001, 32'h807F_FFFF,
                  32'h0080_0000, 32'h7F7F_FFFF, 32'hBF80_0000,
                  32'h7FC0_0000, 32'h7F80_0001, 32'hFFFF_FFFF,
                  32'hFF80_0001, 32'h7FBF_FFFF, 32'h0000_0000};
        types = '{5'b01000, 5'b01000, 5'b00001, 5'b00001, 5'b00100,
                  5'b00100, 5'b00010, 5'b00010, 5'b00010, 5'b10000,
                  5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00001};
        // {sign, is_snan, is_qnan}
        flags = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b000, 3'b100,
                  3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b101,
                  3'b110, 3'b010, 3'b000};
        for (int i = 0; i < 15; i++) begin
            apply(1'b1, nums[i]);
            total++;
            if (bus.out_valid !== 1'b1 ||
                observed() !== {types[i], flags[i]}) begin
                bad++;
                $display("FAIL directed_%h got v=%b o=%b want v=1 o=%b",
                         nums[i], bus.out_valid, observed(),
                         {types[i], flags[i]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] nums [3];
        logic [4:0]  types [3];
        nums  = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000};
        types = '{5'b00001, 5'b01000, 5'b10000};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, nums[i]);
            total++;
            if (bus.out_valid !== 1'b1 || bus.float_type !== types[i]) begin
                bad++;
                $display("FAIL stream_%0d got v=%b t=%b want v=1 t=%b",
                         i, bus.out_valid, bus.float_type, types[i]);
            end
        end
        apply(1'b0, 32'h0000_0001);
        total++;
        if (bus.out_valid !== 1'b0 || observed() !== 8'b10000_001) begin
            bad++;
            $display("FAIL hold got v=%b o=%b want v=0 o=10000001",
                     bus.out_valid, observed());
        end
        apply(1'b0, 32'hFF80_0000);
        total++;
        if (bus.out_valid !== 1'b0 || observed() !== 8'b10000_001) begin
            bad++;
            $display("FAIL hold2 got v=%b o=%b want v=0 o=10000001",
                     bus.out_valid, observed());
        end
    endtask

    task automatic test_random();
        logic [31:0] n;
        logic        v;
        logic [7:0]  e;
        for (int i = 0; i < 400; i++) begin
            n = $urandom;
            case ($urandom_range(0, 4))
                0: e = 8'h00;
                1: e = 8'hFF;
                2: begin e = 8'hFF; n = n & 32'hFFC0_0000; n = n | 32'h0000_0001; end
                3: begin e = 8'(n / 32'h0080_0000); n = n & 32'hFF80_0000; end
                default: e = 8'(n / 32'h0080_0000);
            endcase
            n = (n & 32'h807F_FFFF) | (32'(e) * 32'h0080_0000);
            v = ($urandom_range(0, 3) != 0);
            apply(v, n);
            total++;
            if (bus.out_valid !== v || observed() !== hold_exp) begin
                bad++;
                $display("FAIL random_%0d n=%h got v=%b o=%b want v=%b o=%b",
                         i, n, bus.out_valid, observed(), v, hold_exp);
            end
            if (bus.out_valid === 1'b1) begin
                total++;
                if ($countones(bus.float_type) != 1) begin
                    bad++;
                    $display("FAIL onehot_%0d got t=%b want one bit set",
                             i, bus.float_type);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(1'b1, 32'h7FC0_0000);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || observed() !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got v=%b o=%b want v=0 o=00000000",
                     bus.out_valid, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 32'hBF80_0000);
        total++;
        if (bus.out_valid !== 1'b1 || observed() !== 8'b00010_100) begin
            bad++;
            $display("FAIL post_reset got v=%b o=%b want v=1 o=00010100",
                     bus.out_valid, observed());
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        hold_exp     = 8'h00;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.num      = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
